muldiv_sequencer: RTL and testbench

- Multi-cycle RV32M multiply/divide unit beside the single-cycle ALU.
- Sequences a radix-2 shift-add (multiply) or restoring shift-subtract (divide) datapath over XLEN iterations.
- Raises busy so the core stalls the PC and register-file write for M-extension instructions.
- Decoded by funct3 when Funct7 = 7'b0000001 and opcode = OP.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_sequencer.sv | 165 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: funct3 codes, FSM states and
// operand-signedness helpers.
package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPrep  = 3'd1,
        StIter  = 3'd2,
        StFixup = 3'd3,
        StDone  = 3'd4
    } state_e;

    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic f3_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic f3_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Accumulator layout: multiply {partial product, multiplier}, divide {remainder, dividend/quotient}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                is_div_i,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     opd_i,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   trial;
    logic            borrow;
    logic [XLEN-1:0] new_rem;

    always_comb begin
        sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opd_i} : '0);
        trial   = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        borrow  = trial < {1'b0, opd_i};
        // Kept remainder is always below the divisor, so it fits in XLEN bits.
        new_rem = borrow ? trial[XLEN-1:0] : (trial[XLEN-1:0] - opd_i);
        if (is_div_i) begin
            acc_o = {new_rem, acc_i[XLEN-2:0], ~borrow};
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit (IDLE, PREP, ITER, FIXUP, DONE).
// Optional MULDIV_EARLY_OUT_EN skips the iterations for zero/special operands.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opd_q, opd_d;
    logic                neg_q, neg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     res_q, res_d;

    logic                is_div, is_rem;
    logic                sa, sb;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_zero, div_ovf, mul_zero, special;
    logic [XLEN-1:0]     special_res;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem, fix_res;
    logic [2*XLEN-1:0]   step_acc;

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div_i (is_div),
        .acc_i    (acc_q),
        .opd_i    (opd_q),
        .acc_o    (step_acc)
    );

    // Operand decode and special-case detection from the latched request.
    always_comb begin
        is_div   = f3_is_div(f3_q);
        is_rem   = f3_q[1];
        sa       = f3_a_signed(f3_q) & a_q[XLEN-1];
        sb       = f3_b_signed(f3_q) & b_q[XLEN-1];
        mag_a    = sa ? (~a_q + 1'b1) : a_q;
        mag_b    = sb ? (~b_q + 1'b1) : b_q;
        div_zero = is_div & (b_q == '0);
        div_ovf  = is_div & ~f3_q[0] & (a_q == MinNeg) & (b_q == '1);
        mul_zero = ~is_div & ((a_q == '0) | (b_q == '0));
        special  = div_zero | div_ovf | mul_zero;

        special_res = '0;
        if (div_zero) begin
            special_res = is_rem ? a_q : '1;
        end else if (div_ovf) begin
            special_res = is_rem ? '0 : a_q;
        end
    end

    // Sign correction and result selection.
    always_comb begin
        prod = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        if (special) begin
            fix_res = special_res;
        end else if (is_div) begin
            fix_res = is_rem ? rem : quo;
        end else if (f3_q == F3_MUL) begin
            fix_res = prod[XLEN-1:0];
        end else begin
            fix_res = prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    f3_d    = funct3_i;
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    state_d = StPrep;
                end else begin
                    state_d = StIdle;
                end
            end
            StPrep: begin
                // Remainder takes the dividend's sign; product and quotient take sa^sb.
                neg_d = (is_div & is_rem) ? sa : (sa ^ sb);
                acc_d = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                opd_d = is_div ? mag_b : mag_a;
                cnt_d = CNT_W'(XLEN - 1);
`ifdef MULDIV_EARLY_OUT_EN
                // FIXUP already forces special results, so the iterations can be skipped.
                state_d = special ? StFixup : StIter;
`else
                state_d = StIter;
`endif
            end
            StIter: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                res_d   = fix_res;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            f3_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign busy_o   = (state_q == StPrep) || (state_q == StIter) || (state_q == StFixup);
    assign done_o   = (state_q == StDone);
    assign result_o = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer; expected latency follows MULDIV_EARLY_OUT_EN.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int unsigned XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EarlyBuild = 1'b1;
`else
    localparam bit EarlyBuild = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b0;
    logic            start_i = 1'b0;
    logic [2:0]      funct3_i = '0;
    logic [XLEN-1:0] op_a_i = '0;
    logic [XLEN-1:0] op_b_i = '0;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(
        .XLEN (XLEN)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives start from the current time; returns #1 after the edge where done rises.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit special, input bit glitch,
                          input string tag);
        int edges;
        int lat;
        bit busy_ok;
        lat = (EarlyBuild && special) ? 2 : XLEN + 2;
        start_i  = 1'b1;
        funct3_i = f3;
        op_a_i   = a;
        op_b_i   = b;
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        funct3_i = 3'($urandom);
        op_a_i   = $urandom;
        op_b_i   = $urandom;
        check_eq({tag, " busy after accept"}, 32'(busy_o), 32'd1);
        busy_ok = 1'b1;
        edges   = 0;
        while (!done_o && edges < 100) begin
            if (glitch && edges == 5) begin
                start_i  = 1'b1;
                funct3_i = F3_DIVU;
                op_a_i   = 32'd100;
                op_b_i   = 32'd7;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk_i);
            #1;
            edges++;
            if (!done_o && !busy_o) busy_ok = 1'b0;
        end
        start_i = 1'b0;
        check_eq({tag, " latency"}, 32'(edges), 32'(lat));
        check_eq({tag, " busy held"}, 32'(busy_ok), 32'd1);
        check_eq({tag, " busy at done"}, 32'(busy_o), 32'd0);
        check_eq({tag, " result"}, result_o, exp);
    endtask

    task automatic idle_check(input logic [31:0] exp, input string tag);
        @(posedge clk_i);
        #1;
        check_eq({tag, " done one cycle"}, 32'(done_o), 32'd0);
        check_eq({tag, " result held"}, result_o, exp);
    endtask

    initial begin
        #1 reset_i = 1'b1;
        #10;
        check_eq("reset busy", 32'(busy_o), 32'd0);
        check_eq("reset done", 32'(done_o), 32'd0);
        check_eq("reset result", result_o, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0, "mul");
        idle_check(32'hFFFF_FFEB, "mul");
        run_op(F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, "mulh");
        idle_check(32'h4000_0000, "mulh");
        run_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, "mulhu");
        idle_check(32'hFFFF_FFFE, "mulhu");
        run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "mulhsu");
        idle_check(32'hFFFF_FFFF, "mulhsu");

        // Abandon an operation ten cycles into ITER.
        start_i  = 1'b1;
        funct3_i = F3_MULHU;
        op_a_i   = 32'hFFFF_FFFF;
        op_b_i   = 32'hFFFF_FFFF;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (11) @(posedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        check_eq("midop reset busy", 32'(busy_o), 32'd0);
        check_eq("midop reset done", 32'(done_o), 32'd0);
        check_eq("midop reset result", result_o, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        run_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, "divu after reset");
        idle_check(32'd14, "divu");
        run_op(F3_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, "remu");
        idle_check(32'd2, "remu");
        run_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, "div neg");
        idle_check(32'hFFFF_FFFD, "div neg");
        run_op(F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, "rem neg");
        idle_check(32'hFFFF_FFFF, "rem neg");
        run_op(F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, "divu by zero");
        idle_check(32'hFFFF_FFFF, "divu by zero");
        run_op(F3_REM, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0, "rem by zero");
        idle_check(32'd5, "rem by zero");
        run_op(F3_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, "div neg by zero");
        idle_check(32'hFFFF_FFFF, "div neg by zero");
        run_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, "div ovf");
        idle_check(32'h8000_0000, "div ovf");
        run_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, "rem ovf");
        idle_check(32'd0, "rem ovf");
        run_op(F3_MUL, 32'd0, 32'd12345, 32'd0, 1'b1, 1'b0, "mul zero");
        idle_check(32'd0, "mul zero");
        run_op(F3_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b0, 1'b0, "mulhu 2^32");
        idle_check(32'd1, "mulhu 2^32");
        run_op(F3_REMU, 32'h1234_5678, 32'h0000_0100, 32'h78, 1'b0, 1'b0, "remu low byte");
        idle_check(32'h78, "remu low byte");

        // Start pulsed mid-operation is ignored; the next start lands in the DONE cycle.
        run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1, "mul ignore start");
        run_op(F3_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, "back to back remu");
        idle_check(32'd2, "back to back remu");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
